// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: data-memory initiator for the sequential Y86 core.
// Decodes icode, issues one read or write per instruction over a valid/ready
// request channel, and captures read data from a valid-only response channel.
// Optional build macro MEM_ADDR_CHECK_EN: addresses >= MEM_WORDS complete
// immediately with mem_err instead of issuing a request.
module mem_access_ctrl #(
  parameter int unsigned ADDR_W    = 64,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned MEM_WORDS = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [3:0]        icode,
  input  logic [DATA_W-1:0] valA,
  input  logic [DATA_W-1:0] valP,
  input  logic [DATA_W-1:0] valE,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_rdata,
  output logic [DATA_W-1:0] valM,
  output logic              done,
  output logic              busy,
  output logic              mem_err
);

  localparam logic [3:0] IC_RMMOVQ = 4'h4;
  localparam logic [3:0] IC_MRMOVQ = 4'h5;
  localparam logic [3:0] IC_CALL   = 4'h8;
  localparam logic [3:0] IC_RET    = 4'h9;
  localparam logic [3:0] IC_PUSHQ  = 4'hA;
  localparam logic [3:0] IC_POPQ   = 4'hB;

  // A zero-sized memory makes every access out of range; reject it early.
  if (MEM_WORDS == 0) begin : g_bad_cfg
    $error("mem_access_ctrl: MEM_WORDS must be nonzero");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state;
  state_t state_n;

  logic              acc_c;
  logic              we_c;
  logic [ADDR_W-1:0] addr_c;
  logic [DATA_W-1:0] wdata_c;

  // Instruction decode: access kind, address source and store data.
  always_comb begin
    acc_c   = 1'b0;
    we_c    = 1'b0;
    addr_c  = '0;
    wdata_c = '0;
    unique case (icode)
      IC_MRMOVQ: begin
        acc_c  = 1'b1;
        addr_c = ADDR_W'(valE);
      end
      IC_RET, IC_POPQ: begin
        acc_c  = 1'b1;
        addr_c = ADDR_W'(valA);
      end
      IC_RMMOVQ, IC_PUSHQ: begin
        acc_c   = 1'b1;
        we_c    = 1'b1;
        addr_c  = ADDR_W'(valE);
        wdata_c = valA;
      end
      IC_CALL: begin
        acc_c   = 1'b1;
        we_c    = 1'b1;
        addr_c  = ADDR_W'(valE);
        wdata_c = valP;
      end
      default: ;
    endcase
  end

`ifdef MEM_ADDR_CHECK_EN
  localparam int unsigned CMP_W = (ADDR_W > 32) ? ADDR_W : 32;

  logic oob_c;
  logic err_n;

  // Out-of-range check on the address that would be issued.
  always_comb begin
    oob_c = (CMP_W'(addr_c) >= CMP_W'(MEM_WORDS));
  end
`endif

  // Next-state logic.
  always_comb begin
    state_n = state;
`ifdef MEM_ADDR_CHECK_EN
    err_n   = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (start) begin
          if (!acc_c) begin
            state_n = DONE;
          end
`ifdef MEM_ADDR_CHECK_EN
          else if (oob_c) begin
            state_n = DONE;
            err_n   = 1'b1;
          end
`endif
          else begin
            state_n = REQ;
          end
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          state_n = mem_req_we ? DONE : RSP;
        end
      end
      RSP: begin
        if (mem_rsp_valid) begin
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State register and registered outputs derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      mem_req_valid <= 1'b0;
      mem_req_we    <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      valM          <= '0;
      done          <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_n;
      mem_req_valid <= (state_n == REQ);
      done          <= (state_n == DONE);
      busy          <= (state_n != IDLE);
      if ((state == IDLE) && start && acc_c) begin
        mem_req_we    <= we_c;
        mem_req_addr  <= addr_c;
        mem_req_wdata <= wdata_c;
      end
      if ((state == RSP) && mem_rsp_valid) begin
        valM <= mem_rsp_rdata;
      end
    end
  end

`ifdef MEM_ADDR_CHECK_EN
  // Error flag lives only for the done pulse of a rejected access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_err <= 1'b0;
    end else begin
      mem_err <= err_n;
    end
  end
`else
  assign mem_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl with a transaction-level reference model.
module tb_mem_access_ctrl;

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;
  localparam int unsigned MW = 128;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [3:0]    icode;
  logic [DW-1:0] valA;
  logic [DW-1:0] valP;
  logic [DW-1:0] valE;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic          mem_req_we;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_wdata;
  logic          mem_rsp_valid;
  logic [DW-1:0] mem_rsp_rdata;
  logic [DW-1:0] valM;
  logic          done;
  logic          busy;
  logic          mem_err;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] model_valM = '0;

  mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .MEM_WORDS(MW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .icode(icode),
    .valA(valA), .valP(valP), .valE(valE),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_rdata(mem_rsp_rdata), .valM(valM), .done(done),
    .busy(busy), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Y86 memory-stage semantics: what each icode does to memory.
  function automatic void model_decode(input logic [3:0] ic, input logic [63:0] a,
                                       input logic [63:0] p, input logic [63:0] e,
                                       output bit acc, output bit we,
                                       output logic [63:0] addr, output logic [63:0] wd);
    acc = 1'b1; we = 1'b0; addr = e; wd = '0;
    case (ic)
      4'h5: ;
      4'h9, 4'hB: addr = a;
      4'h4, 4'hA: begin we = 1'b1; wd = a; end
      4'h8: begin we = 1'b1; wd = p; end
      default: begin acc = 1'b0; addr = '0; end
    endcase
  endfunction

  // One instruction: rdly cycles of backpressure, response sdly cycles after handshake.
  task automatic run_op(input logic [3:0] ic, input logic [63:0] a, input logic [63:0] p,
                        input logic [63:0] e, input int rdly, input int sdly,
                        input bit stray_same, input logic [63:0] rdata);
    bit acc, we, err, issue, rd_wait;
    logic [63:0] addr, wd;
    int s_h, done_at;
    model_decode(ic, a, p, e, acc, we, addr, wd);
    err = 1'b0;
`ifdef MEM_ADDR_CHECK_EN
    err = acc && (addr >= 64'(MW));
`endif
    issue   = acc && !err;
    s_h     = 1 + rdly;
    done_at = !issue ? 1 : (we ? 2 + rdly : 2 + rdly + sdly);
    @(negedge clk);
    icode = ic; valA = a; valP = p; valE = e;
    start = 1'b1; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    for (int i = 1; i <= done_at + 1; i++) begin
      @(negedge clk);
      start         = 1'b0;
      icode         = 4'($urandom);
      mem_rsp_rdata = {$urandom, $urandom};
      rd_wait       = issue && !we && (i >= s_h) && (i < done_at);
      mem_req_ready = (issue && i <= s_h) ? (i == s_h) : 1'($urandom);
      mem_rsp_valid = rd_wait ? 1'b0 : 1'($urandom);
      chk("valid", 64'(mem_req_valid), 64'(issue && i <= s_h));
      chk("busy", 64'(busy), 64'(i <= done_at));
      chk("done", 64'(done), 64'(i == done_at));
      if (issue && i <= s_h) begin
        chk("we", 64'(mem_req_we), 64'(we));
        chk("addr", mem_req_addr, addr);
        if (we) chk("wdata", mem_req_wdata, wd);
      end
      if (rd_wait && i == s_h && stray_same) mem_rsp_valid = 1'b1;
      if (rd_wait && i == s_h + sdly) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = rdata;
      end
      if (i == done_at) begin
        if (issue && !we) model_valM = rdata;
        chk("valM_done", valM, model_valM);
        chk("mem_err", 64'(mem_err), 64'(err));
      end
    end
    chk("valM_hold", valM, model_valM);
  endtask

  logic [3:0] mem_ops [6];

  initial begin
    mem_ops[0] = 4'h4; mem_ops[1] = 4'h5; mem_ops[2] = 4'h8;
    mem_ops[3] = 4'h9; mem_ops[4] = 4'hA; mem_ops[5] = 4'hB;
    rst_n = 1'b0; start = 1'b0; icode = '0; valA = '0; valP = '0; valE = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_valM", valM, 64'd0);
    chk("rst_addr", mem_req_addr, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(4'h4, 64'hDEAD, 64'h0, 64'h10, 0, 1, 1'b0, 64'h0);
    run_op(4'h8, 64'h0, 64'h40, 64'h7F, 3, 1, 1'b0, 64'h0);
    run_op(4'hB, 64'h20, 64'h0, 64'h28, 0, 2, 1'b1, 64'h1234);
    run_op(4'h6, 64'h5, 64'h6, 64'h7, 0, 1, 1'b0, 64'h0);
    chk("nonmem_valM", valM, 64'h1234);
    run_op(4'h5, 64'h0, 64'h0, 64'h80, 0, 1, 1'b0, 64'hCAFE);
    run_op(4'h9, 64'h7F, 64'h0, 64'h0, 2, 3, 1'b1, 64'hBEEF);

    for (int n = 0; n < 300; n++) begin
      logic [3:0]  ic;
      logic [63:0] a, e;
      ic = ($urandom_range(0, 3) != 0) ? mem_ops[$urandom_range(0, 5)] : 4'($urandom);
      a  = ($urandom_range(0, 1) != 0) ? 64'($urandom_range(0, 200)) : {$urandom, $urandom};
      e  = ($urandom_range(0, 1) != 0) ? 64'($urandom_range(0, 200)) : {$urandom, $urandom};
      run_op(ic, a, {$urandom, $urandom}, e, $urandom_range(0, 4), $urandom_range(1, 4),
             1'($urandom), {$urandom, $urandom});
    end

    // Asynchronous reset in the middle of a stalled request.
    @(negedge clk);
    icode = 4'h4; valA = 64'h55; valE = 64'h11; start = 1'b1;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("mid_valid", 64'(mem_req_valid), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(mem_req_valid), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_we", 64'(mem_req_we), 64'd0);
    chk("arst_addr", mem_req_addr, 64'd0);
    chk("arst_wdata", mem_req_wdata, 64'd0);
    chk("arst_valM", valM, 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_err", 64'(mem_err), 64'd0);
    model_valM = '0;
    @(negedge clk);
    rst_n = 1'b1;
    mem_req_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_busy", 64'(busy), 64'd0);
    chk("post_valid", 64'(mem_req_valid), 64'd0);
    run_op(4'hB, 64'h3, 64'h0, 64'h0, 1, 1, 1'b0, 64'h77);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
